// File: rtl/hptdc_usb_reader.sv
// Purpose : drain 32-bit HPTDC hit words from the capture FIFO and send each one
//           as bytes (LSB byte first) to an FT-style synchronous USB FIFO bridge.
// Latency : REQ until fifo_output_ready, then one SEND cycle per accepted byte.
//           usb_wr_n/usb_data are registered, so each write shows one cycle later.
// Backpr. : usb_txe_n=1 holds the current byte with no timeout. Only REQ can time out.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   enable                 allows new word fetches; a word already in flight always finishes
//   fifo_empty, fifo_data,
//   fifo_output_ready      capture FIFO read side (output_ready pulses while data is valid)
//   fifo_read_enable       read strobe to the capture FIFO (the only combinational output)
//   usb_txe_n              0 = bridge can accept a byte this cycle
//   usb_wr_n, usb_data     registered byte write to the bridge
//   busy                   high whenever the reader is not idle
//   error                  sticky fetch timeout; only reset clears it
//   words_sent             count of fully sent words, wraps
module hptdc_usb_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_output_ready,
    input  logic                  usb_txe_n,
    output logic                  usb_wr_n,
    output logic [BYTE_WIDTH-1:0] usb_data,
    output logic                  busy,
    output logic                  error,
    output logic [31:0]           words_sent
);

    localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                              state, state_nxt;
    logic [IDX_W-1:0]                    byte_idx, byte_idx_nxt;
    logic [DATA_WIDTH-1:0]               word_q, word_nxt;
    logic [TMO_W-1:0]                    tmo_cnt, tmo_nxt, tmo_inc;
    logic                                wr_n_nxt;
    logic [BYTE_WIDTH-1:0]               data_nxt;
    logic                                error_nxt;
    logic [31:0]                         words_nxt;
    logic                                fetch_ok;
    logic                                last_byte;
    logic [NBYTES-1:0][BYTE_WIDTH-1:0]   word_bytes;

    assign word_bytes = word_q;
    assign fetch_ok   = enable & ~fifo_empty;
    assign last_byte  = (byte_idx == IDX_W'(NBYTES - 1));
    assign tmo_inc    = tmo_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            byte_idx   <= '0;
            word_q     <= '0;
            tmo_cnt    <= '0;
            usb_wr_n   <= 1'b1;
            usb_data   <= '0;
            busy       <= 1'b0;
            error      <= 1'b0;
            words_sent <= '0;
        end else begin
            state      <= state_nxt;
            byte_idx   <= byte_idx_nxt;
            word_q     <= word_nxt;
            tmo_cnt    <= tmo_nxt;
            usb_wr_n   <= wr_n_nxt;
            usb_data   <= data_nxt;
            // busy is registered from the next state so it tracks the state register exactly
            busy       <= (state_nxt != IDLE);
            error      <= error_nxt;
            words_sent <= words_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        byte_idx_nxt     = byte_idx;
        word_nxt         = word_q;
        tmo_nxt          = tmo_cnt;
        wr_n_nxt         = 1'b1;
        data_nxt         = usb_data;
        error_nxt        = error;
        words_nxt        = words_sent;
        fifo_read_enable = 1'b0;

        case (state)
            IDLE: begin
                if (fetch_ok) begin
                    state_nxt = REQ;
                    tmo_nxt   = '0;
                end
            end

            REQ: begin
                // Keep requesting until the FIFO answers, then drop the strobe in that
                // cycle. A FIFO that defers the read still sees only one pop.
                fifo_read_enable = ~fifo_output_ready;
                if (fifo_output_ready) begin
                    word_nxt     = fifo_data;
                    byte_idx_nxt = '0;
                    state_nxt    = SEND;
                end else if (fifo_empty) begin
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        error_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            SEND: begin
                if (!usb_txe_n) begin
                    wr_n_nxt = 1'b0;
                    data_nxt = word_bytes[byte_idx];
                    if (last_byte) begin
                        byte_idx_nxt = '0;
                        words_nxt    = words_sent + 32'd1;
                        tmo_nxt      = '0;
                        state_nxt    = fetch_ok ? REQ : IDLE;
                    end else begin
                        byte_idx_nxt = byte_idx + 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hptdc_usb_reader.sv
// Testbench for hptdc_usb_reader. The capture FIFO is a queue that can defer reads.
// The reference model expects each word pushed to appear LSB byte first, and
// words_sent to track the number of complete words.
module tb_hptdc_usb_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [31:0] fifo_data;
    logic        fifo_output_ready;
    logic        usb_txe_n;
    logic        usb_wr_n;
    logic [7:0]  usb_data;
    logic        busy;
    logic        error;
    logic [31:0] words_sent;

    always #5 clk = ~clk;

    hptdc_usb_reader #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .TIMEOUT(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_read_enable  (fifo_read_enable),
        .fifo_data         (fifo_data),
        .fifo_output_ready (fifo_output_ready),
        .usb_txe_n         (usb_txe_n),
        .usb_wr_n          (usb_wr_n),
        .usb_data          (usb_data),
        .busy              (busy),
        .error             (error),
        .words_sent        (words_sent)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fq[$];        // capture FIFO contents
    int          stall = 0;    // read strobes the FIFO ignores before it answers
    int          pops, re_cnt, overlap, cyc;
    bit          rand_txe = 0;
    logic [7:0]  got[$];       // bytes seen on the USB bus
    int          wr_cyc[$];
    logic [7:0]  exp_bytes[$]; // reference model byte stream
    int          exp_words = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        got.delete();
        wr_cyc.delete();
        exp_bytes.delete();
        re_cnt  = 0;
        pops    = 0;
        overlap = 0;
    endtask

    // Push a word into the FIFO and into the reference model.
    task automatic push_word(logic [31:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
        for (int i = 0; i < 4; i++) exp_bytes.push_back(w[8*i +: 8]);
        exp_words++;
    endtask

    // Runs one clock cycle. It starts and ends at a negedge.
    task automatic cycle();
        logic re;
        re = fifo_read_enable;
        if (re) re_cnt++;
        if (re && fifo_output_ready) overlap++;
        @(posedge clk);
        #1;
        cyc++;
        fifo_output_ready = 1'b0;
        if (re) begin
            if (stall > 0) stall--;
            else if (fq.size() > 0) begin
                fifo_data         = fq.pop_front();
                fifo_output_ready = 1'b1;
                pops++;
            end
        end
        fifo_empty = (fq.size() == 0);
        if (!usb_wr_n) begin
            got.push_back(usb_data);
            wr_cyc.push_back(cyc);
        end
        if (rand_txe) usb_txe_n = ($urandom_range(0, 2) == 0);
        @(negedge clk);
    endtask

    task automatic run_idle(string tag, int budget);
        int n;
        n = 0;
        cycle();
        while ((busy || (enable && !fifo_empty)) && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_reached_idle"}, 64'(busy || (enable && !fifo_empty)), 64'd0);
    endtask

    task automatic check_stream(string tag);
        check({tag, "_nbytes"}, 64'(got.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), 64'(got[i]), 64'(exp_bytes[i]));
    endtask

    initial begin
        int n, req;
        logic [31:0] w;

        rst_n = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
        fifo_output_ready = 1'b0; usb_txe_n = 1'b0; cyc = 0;
        repeat (2) @(negedge clk);
        check("rst_read_enable", 64'(fifo_read_enable), 64'd0);
        check("rst_wr_n",        64'(usb_wr_n),         64'd1);
        check("rst_usb_data",    64'(usb_data),         64'd0);
        check("rst_busy",        64'(busy),             64'd0);
        check("rst_error",       64'(error),            64'd0);
        check("rst_words_sent",  64'(words_sent),       64'd0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Single word
        clear_log();
        push_word(32'hA1B2C3D4);
        enable = 1'b1;
        run_idle("single", 40);
        check("single_re_cycles", 64'(re_cnt), 64'd1);
        check("single_pops", 64'(pops), 64'd1);
        check_stream("single");
        if (wr_cyc.size() >= 4)
            check("single_consecutive", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
        check("single_words_sent", 64'(words_sent), 64'(exp_words));
        check("single_busy", 64'(busy), 64'd0);

        // Three back-to-back words
        clear_log();
        push_word(32'h01234567); push_word(32'h89ABCDEF); push_word(32'hDEADBEEF);
        run_idle("three", 100);
        check("three_pops", 64'(pops), 64'd3);
        check("three_re_cycles", 64'(re_cnt), 64'd3);
        check_stream("three");
        check("three_words_sent", 64'(words_sent), 64'(exp_words));

        // Bridge stalls after the second byte
        clear_log();
        push_word(32'h11223344);
        n = 0;
        while (got.size() < 2 && n < 30) begin cycle(); n++; end
        check("stall_two_bytes", 64'(got.size()), 64'd2);
        usb_txe_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("stall_wr_n_%0d", i), 64'(usb_wr_n), 64'd1);
            check($sformatf("stall_data_%0d", i), 64'(usb_data), 64'h33);
        end
        usb_txe_n = 1'b0;
        run_idle("stall", 40);
        check_stream("stall");
        check("stall_words_sent", 64'(words_sent), 64'(exp_words));

        // FIFO answers only after three read strobe cycles
        clear_log();
        stall = 2;
        push_word(32'hCAFEF00D);
        run_idle("delay", 40);
        check("delay_re_cycles", 64'(re_cnt), 64'd3);
        check("delay_overlap", 64'(overlap), 64'd0);
        check("delay_pops", 64'(pops), 64'd1);
        check("delay_error", 64'(error), 64'd0);
        check_stream("delay");
        check("delay_words_sent", 64'(words_sent), 64'(exp_words));

        // FIFO never answers, so the fetch must time out
        clear_log();
        stall = 1000;
        fq.push_back(32'h5A5A5A5A);
        fifo_empty = 1'b0;
        n = 0; req = 0;
        while (!error && n < 100) begin
            if (busy) req++;
            cycle();
            n++;
        end
        enable = 1'b0;
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_req_cycles", 64'(req), 64'd16);
        check("tmo_busy", 64'(busy), 64'd0);
        repeat (4) cycle();
        check("tmo_error_sticky", 64'(error), 64'd1);
        check("tmo_no_writes", 64'(got.size()), 64'd0);
        fq.delete(); stall = 0; fifo_empty = 1'b1;

        // A sticky error must not block later transfers
        clear_log();
        enable = 1'b1;
        push_word($urandom); push_word($urandom);
        run_idle("post_err", 80);
        check_stream("post_err");
        check("post_err_error", 64'(error), 64'd1);
        check("post_err_words_sent", 64'(words_sent), 64'(exp_words));

        // Reset in the middle of a word
        clear_log();
        w = $urandom;
        fq.push_back(w);
        fifo_empty = 1'b0;
        n = 0;
        while (got.size() < 2 && n < 30) begin cycle(); n++; end
        check("mid_rst_two_bytes", 64'(got.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_n",       64'(usb_wr_n),         64'd1);
        check("mid_rst_data",       64'(usb_data),         64'd0);
        check("mid_rst_busy",       64'(busy),             64'd0);
        check("mid_rst_words_sent", 64'(words_sent),       64'd0);
        check("mid_rst_error",      64'(error),            64'd0);
        check("mid_rst_read_en",    64'(fifo_read_enable), 64'd0);
        enable = 1'b0; fq.delete(); fifo_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        repeat (6) cycle();
        check("mid_rst_no_writes", 64'(got.size()), 64'd0);
        clear_log();
        exp_words = 0;
        push_word(32'h0BADF00D);
        enable = 1'b1;
        run_idle("after_rst", 40);
        check_stream("after_rst");
        check("after_rst_words_sent", 64'(words_sent), 64'(exp_words));

        // Random words with a random FIFO answer delay and bridge backpressure
        clear_log();
        rand_txe = 1;
        for (int b = 0; b < 10; b++) begin
            stall = $urandom_range(0, 3);
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) push_word($urandom);
            run_idle($sformatf("rand%0d", b), 600);
        end
        rand_txe = 0;
        usb_txe_n = 1'b0;
        check_stream("rand");
        check("rand_pops", 64'(pops), 64'(exp_bytes.size() / 4));
        check("rand_words_sent", 64'(words_sent), 64'(exp_words));
        check("rand_error", 64'(error), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
